// File: rtl/xu0_dlmzb_ctl_pkg.sv
// xu0_dlmzb_ctl_pkg: shared constants and pipeline-stage types for the
// dlmzb issue/return controller.
//   TID_W / ITAG_W       : thread id and instruction tag widths
//   XER_IN_W / XER_W     : SO/OV/CA operand width, full dlmzb XER result width
//   CR_W / RT_W / OP_W   : CR field, byte-count result and operand widths
package xu0_dlmzb_ctl_pkg;

  localparam int TID_W    = 1;
  localparam int ITAG_W   = 7;
  localparam int XER_IN_W = 3;
  localparam int XER_W    = 10;
  localparam int CR_W     = 4;
  localparam int RT_W     = 4;
  localparam int OP_W     = 32;

  // Operand stage: feeds the shared dlmzb unit directly.
  typedef struct packed {
    logic                valid;
    logic [TID_W-1:0]    tid;
    logic [ITAG_W-1:0]   itag;
    logic                rc;
    logic [XER_IN_W-1:0] xer;
    logic [OP_W-1:0]     rs1;
    logic [OP_W-1:0]     rs2;
  } s1_t;

  // Result stage: drives the res_* return interface.
  typedef struct packed {
    logic              valid;
    logic [TID_W-1:0]  tid;
    logic [ITAG_W-1:0] itag;
    logic              rc;
    logic [RT_W-1:0]   rt;
    logic [XER_W-1:0]  xer;
    logic [CR_W-1:0]   cr;
  } s2_t;

endpackage

// File: rtl/xu0_dlmzb_arb.sv
// xu0_dlmzb_arb: two-thread request arbiter for the dlmzb controller.
//   nclk, rst            : clock, async active-high reset
//   t0/t1_req_val        : per-thread request
//   flush[0:1]           : per-thread kill; a flushed thread is not eligible
//   s1_free              : operand stage can take a new entry this cycle
//   t0/t1_req_rdy        : per-thread accept (transfer on val & rdy)
// With XU0_DLMZB_RR_EN defined, contention goes to the thread that did not
// win last; otherwise thread 0 always wins. last_grant resets to 1 so that
// thread 0 wins the first contested cycle.
module xu0_dlmzb_arb (
  input  logic       nclk,
  input  logic       rst,
  input  logic       t0_req_val,
  input  logic       t1_req_val,
  input  logic [0:1] flush,
  input  logic       s1_free,
  output logic       t0_req_rdy,
  output logic       t1_req_rdy
);

  logic last_grant;
  logic elig0, elig1;
  logic gnt0, gnt1;

  assign elig0 = t0_req_val & ~flush[0];
  assign elig1 = t1_req_val & ~flush[1];

`ifdef XU0_DLMZB_RR_EN
  assign gnt0 = elig0 & (~elig1 | last_grant);
  assign gnt1 = elig1 & (~elig0 | ~last_grant);
`else
  assign gnt0 = elig0;
  assign gnt1 = elig1 & ~elig0;
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  assign t0_req_rdy = s1_free & gnt0;
  assign t1_req_rdy = s1_free & gnt1;

  // Only a real transfer moves the round-robin pointer.
  always_ff @(posedge nclk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (t0_req_val & t0_req_rdy) begin
      last_grant <= 1'b0;
    end else if (t1_req_val & t1_req_rdy) begin
      last_grant <= 1'b1;
    end
  end

endmodule

// File: rtl/xu0_dlmzb_ctl.sv
// xu0_dlmzb_ctl: two-stage issue/return controller wrapping a shared,
// externally instantiated combinational dlmzb unit for two threads.
//   nclk, rst             : clock, async active-high reset
//   tN_req_*              : per-thread request (val/rdy, rs1, rs2, xer, rc, itag)
//   flush[0:1]            : per-thread kill of in-flight entries
//   ctl_dlm_ex2_*         : operands to the dlmzb unit (from S1, zero when empty)
//   dlm_ctl_ex2_*         : dlmzb unit results, captured into S2
//   res_*                 : result return (valid/ready), res_cr_we = captured rc
// Optional feature: define XU0_DLMZB_RR_EN for round-robin arbitration.
// Handshakes: a request transfers on an edge where val & rdy; a result
// transfers on an edge where res_val & res_rdy; S2 is frozen otherwise.
module xu0_dlmzb_ctl
  import xu0_dlmzb_ctl_pkg::*;
(
  input  logic                nclk,
  input  logic                rst,
  input  logic                t0_req_val,
  input  logic                t1_req_val,
  output logic                t0_req_rdy,
  output logic                t1_req_rdy,
  input  logic [32:63]        t0_req_rs1,
  input  logic [32:63]        t0_req_rs2,
  input  logic [0:XER_IN_W-1] t0_req_xer,
  input  logic                t0_req_rc,
  input  logic [0:ITAG_W-1]   t0_req_itag,
  input  logic [32:63]        t1_req_rs1,
  input  logic [32:63]        t1_req_rs2,
  input  logic [0:XER_IN_W-1] t1_req_xer,
  input  logic                t1_req_rc,
  input  logic [0:ITAG_W-1]   t1_req_itag,
  input  logic [0:1]          flush,
  output logic [32:63]        ctl_dlm_ex2_rs1,
  output logic [32:63]        ctl_dlm_ex2_rs2,
  output logic [0:XER_IN_W-1] ctl_dlm_ex2_xer,
  input  logic [0:XER_W-1]    dlm_ctl_ex2_xer,
  input  logic [0:CR_W-1]     dlm_ctl_ex2_cr,
  input  logic [60:63]        dlm_ctl_ex2_rt,
  output logic                res_val,
  input  logic                res_rdy,
  output logic                res_tid,
  output logic [0:ITAG_W-1]   res_itag,
  output logic [60:63]        res_rt,
  output logic [0:XER_W-1]    res_xer,
  output logic [0:CR_W-1]     res_cr,
  output logic                res_cr_we
);

  s1_t s1_q, s1_in;
  s2_t s2_q, s2_in;

  logic res_fire, s1_kill, s2_kill, s1_to_s2, s1_free;
  logic acc0, acc1;

  assign res_fire = s2_q.valid & res_rdy;
  assign s1_kill  = s1_q.valid & flush[s1_q.tid];
  assign s2_kill  = s2_q.valid & flush[s2_q.tid];
  // A flushed S1 entry never reaches S2.
  assign s1_to_s2 = s1_q.valid & ~s1_kill & (~s2_q.valid | res_fire);
  assign s1_free  = ~s1_q.valid | s1_to_s2;

  xu0_dlmzb_arb u_arb (
    .nclk       (nclk),
    .rst        (rst),
    .t0_req_val (t0_req_val),
    .t1_req_val (t1_req_val),
    .flush      (flush),
    .s1_free    (s1_free),
    .t0_req_rdy (t0_req_rdy),
    .t1_req_rdy (t1_req_rdy)
  );

  assign acc0 = t0_req_val & t0_req_rdy;
  assign acc1 = t1_req_val & t1_req_rdy;

  always_comb begin
    s1_in       = '0;
    s1_in.valid = 1'b1;
    if (acc1) begin
      s1_in.tid  = 1'b1;
      s1_in.itag = t1_req_itag;
      s1_in.rc   = t1_req_rc;
      s1_in.xer  = t1_req_xer;
      s1_in.rs1  = t1_req_rs1;
      s1_in.rs2  = t1_req_rs2;
    end else begin
      s1_in.tid  = 1'b0;
      s1_in.itag = t0_req_itag;
      s1_in.rc   = t0_req_rc;
      s1_in.xer  = t0_req_xer;
      s1_in.rs1  = t0_req_rs1;
      s1_in.rs2  = t0_req_rs2;
    end
  end

  always_comb begin
    s2_in       = '0;
    s2_in.valid = 1'b1;
    s2_in.tid   = s1_q.tid;
    s2_in.itag  = s1_q.itag;
    s2_in.rc    = s1_q.rc;
    s2_in.rt    = dlm_ctl_ex2_rt;
    s2_in.xer   = dlm_ctl_ex2_xer;
    s2_in.cr    = dlm_ctl_ex2_cr;
  end

  // Invalid stages are zeroed so the unit and res_* see clean zeros.
  always_ff @(posedge nclk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      if (acc0 | acc1) begin
        s1_q <= s1_in;
      end else if (s1_to_s2 | s1_kill) begin
        s1_q <= '0;
      end
      if (s1_to_s2) begin
        s2_q <= s2_in;
      end else if (res_fire | s2_kill) begin
        s2_q <= '0;
      end
    end
  end

  assign ctl_dlm_ex2_rs1 = s1_q.rs1;
  assign ctl_dlm_ex2_rs2 = s1_q.rs2;
  assign ctl_dlm_ex2_xer = s1_q.xer;

  assign res_val   = s2_q.valid;
  assign res_tid   = s2_q.tid;
  assign res_itag  = s2_q.itag;
  assign res_rt    = s2_q.rt;
  assign res_xer   = s2_q.xer;
  assign res_cr    = s2_q.cr;
  assign res_cr_we = s2_q.rc;

endmodule

// File: tb/tb_xu0_dlmzb_ctl.sv
// tb_xu0_dlmzb_ctl: self-checking bench for xu0_dlmzb_ctl with a behavioural
// dlmzb unit attached. Directed steps followed by a randomized phase checked
// against an in-order reference model of the two-deep pipeline.
module tb_xu0_dlmzb_ctl;

  logic        nclk = 1'b0;
  logic        rst;
  logic        t0_req_val, t1_req_val, t0_req_rdy, t1_req_rdy;
  logic [31:0] t0_req_rs1, t0_req_rs2, t1_req_rs1, t1_req_rs2;
  logic [2:0]  t0_req_xer, t1_req_xer;
  logic        t0_req_rc, t1_req_rc;
  logic [6:0]  t0_req_itag, t1_req_itag;
  logic [0:1]  flush;
  logic [31:0] ctl_rs1, ctl_rs2;
  logic [2:0]  ctl_xer;
  logic [9:0]  dlm_xer;
  logic [3:0]  dlm_cr, dlm_rt;
  logic        res_val, res_rdy, res_tid, res_cr_we;
  logic [6:0]  res_itag;
  logic [3:0]  res_rt, res_cr;
  logic [9:0]  res_xer;

  int total = 0;
  int bad   = 0;

  always #5 nclk = ~nclk;

  xu0_dlmzb_ctl dut (
    .nclk(nclk), .rst(rst),
    .t0_req_val(t0_req_val), .t1_req_val(t1_req_val),
    .t0_req_rdy(t0_req_rdy), .t1_req_rdy(t1_req_rdy),
    .t0_req_rs1(t0_req_rs1), .t0_req_rs2(t0_req_rs2), .t0_req_xer(t0_req_xer),
    .t0_req_rc(t0_req_rc), .t0_req_itag(t0_req_itag),
    .t1_req_rs1(t1_req_rs1), .t1_req_rs2(t1_req_rs2), .t1_req_xer(t1_req_xer),
    .t1_req_rc(t1_req_rc), .t1_req_itag(t1_req_itag),
    .flush(flush),
    .ctl_dlm_ex2_rs1(ctl_rs1), .ctl_dlm_ex2_rs2(ctl_rs2), .ctl_dlm_ex2_xer(ctl_xer),
    .dlm_ctl_ex2_xer(dlm_xer), .dlm_ctl_ex2_cr(dlm_cr), .dlm_ctl_ex2_rt(dlm_rt),
    .res_val(res_val), .res_rdy(res_rdy), .res_tid(res_tid), .res_itag(res_itag),
    .res_rt(res_rt), .res_xer(res_xer), .res_cr(res_cr), .res_cr_we(res_cr_we)
  );

  // dlmzb: count bytes of rs1||rs2 up to and including the leftmost zero
  // byte (8 if none). CR = {010 zero in rs1 | 100 zero in rs2 | 001 none, SO}.
  // XER = {SO,OV,CA, 7-bit count}. Packed as {xer[9:0], cr[3:0], rt[3:0]}.
  function automatic logic [17:0] dlmzb_ref(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [2:0]  x);
    logic [63:0] w;
    int          cnt;
    logic [2:0]  crf;
    w   = {a, b};
    cnt = 0;
    crf = 3'b001;
    for (int i = 0; i < 8; i++) begin
      if (cnt == 0 && w[63-8*i -: 8] == 8'h00) begin
        cnt = i + 1;
        crf = (i < 4) ? 3'b010 : 3'b100;
      end
    end
    if (cnt == 0) cnt = 8;
    return {x, 7'(cnt), crf, x[2], 4'(cnt)};
  endfunction

  always_comb {dlm_xer, dlm_cr, dlm_rt} = dlmzb_ref(ctl_rs1, ctl_rs2, ctl_xer);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic tid, input logic [6:0] itag,
                         input logic [3:0] rt, input logic [9:0] xer,
                         input logic [3:0] cr, input logic we);
    chk({tag, "_val"},  res_val,   1);
    chk({tag, "_tid"},  res_tid,   tid);
    chk({tag, "_itag"}, res_itag,  itag);
    chk({tag, "_rt"},   res_rt,    rt);
    chk({tag, "_xer"},  res_xer,   xer);
    chk({tag, "_cr"},   res_cr,    cr);
    chk({tag, "_we"},   res_cr_we, we);
  endtask

  task automatic tick();
    @(posedge nclk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    t0_req_val = 1'b0;
    t1_req_val = 1'b0;
    flush      = 2'b00;
  endtask

  task automatic set_req(input int t, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] x, input logic rc, input logic [6:0] tag);
    if (t == 0) begin
      t0_req_val = 1'b1; t0_req_rs1 = a; t0_req_rs2 = b;
      t0_req_xer = x;    t0_req_rc  = rc; t0_req_itag = tag;
    end else begin
      t1_req_val = 1'b1; t1_req_rs1 = a; t1_req_rs2 = b;
      t1_req_xer = x;    t1_req_rc  = rc; t1_req_itag = tag;
    end
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 2) == 0) w[8*$urandom_range(0, 3) +: 8] = 8'h00;
    return w;
  endfunction

  typedef struct {
    logic        tid;
    logic [6:0]  itag;
    logic [31:0] a, b;
    logic [2:0]  x;
    logic        rc;
    int          st;   // 1 = waiting for the unit, 2 = result presented
  } ent_t;

  initial begin
    ent_t        pipe[$];
    ent_t        nxt[$];
    ent_t        e;
    int          last_g;
    logic        v0, v1, has2, deliver, move, s1_free, e0, e1, g0, g1;
    int          idx1;
    logic [17:0] r;
    logic [31:0] a0, b0, a1, b1;
    logic [2:0]  x0, x1;
    logic        rc0, rc1;
    logic [6:0]  tg0, tg1;

    rst = 1'b1; res_rdy = 1'b1; idle();
    set_req(0, 0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0, 0); idle();
    tick(); tick();
    // reset state
    chk("rst_res_val", res_val, 0);
    chk("rst_res_bus", {res_tid, res_itag, res_rt, res_xer, res_cr, res_cr_we}, 0);
    chk("rst_ctl_rs", {ctl_rs1 | ctl_rs2, ctl_xer}, 0);
    rst = 1'b0;

    // thread 0, zero byte in rs1, first request right after reset release
    set_req(0, 32'h41424300, 32'h11111111, 3'b100, 1'b1, 7'h05);
    settle();
    chk("t0_first_rdy", t0_req_rdy, 1);
    tick(); idle(); settle();
    chk("t0_s1_resval", res_val, 0);
    chk("t0_s1_ctl", ctl_rs1, 32'h41424300);
    tick(); settle();
    chk_res("t0_basic", 1'b0, 7'h05, 4'd4, 10'b1000000100, 4'b0101, 1'b1);
    tick();

    // thread 1, no zero byte
    set_req(1, 32'h01010101, 32'h01010101, 3'b000, 1'b0, 7'h22);
    settle();
    chk("t1_rdy", t1_req_rdy, 1);
    tick(); idle(); tick(); settle();
    chk_res("t1_basic", 1'b1, 7'h22, 4'd8, 10'b0000001000, 4'b0010, 1'b0);
    tick();

    // both threads requesting every cycle
    for (int i = 0; i < 4; i++) begin
      set_req(0, 32'h0, 32'h0, 3'b000, 1'b0, 7'(i));
      set_req(1, 32'h0, 32'h0, 3'b000, 1'b0, 7'(i + 8));
      settle();
`ifdef XU0_DLMZB_RR_EN
      chk("rr_rdy0", t0_req_rdy, (i % 2 == 0));
      chk("rr_rdy1", t1_req_rdy, (i % 2 == 1));
`else
      chk("fix_rdy0", t0_req_rdy, 1);
      chk("fix_rdy1", t1_req_rdy, 0);
`endif
      tick();
    end
    idle(); tick(); tick(); tick();

    // backpressure: fill S1 and S2, hold, then drain in order
    res_rdy = 1'b0;
    set_req(0, 32'h00000000, 32'h0, 3'b000, 1'b0, 7'h01);
    settle(); chk("bp_rdyA", t0_req_rdy, 1); tick();
    set_req(0, 32'hFFFFFFFF, 32'hFFFF00FF, 3'b000, 1'b0, 7'h02);
    settle(); chk("bp_rdyB", t0_req_rdy, 1); tick();
    set_req(0, 32'h12345678, 32'h0, 3'b000, 1'b0, 7'h03);
    set_req(1, 32'h12345678, 32'h0, 3'b000, 1'b0, 7'h04);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp_hold_rdy", {t0_req_rdy, t1_req_rdy}, 0);
      chk("bp_hold_val", res_val, 1);
      chk("bp_hold_itag", res_itag, 7'h01);
      chk("bp_hold_rt", res_rt, 4'd1);
      tick();
    end
    idle(); res_rdy = 1'b1; settle();
    chk_res("bp_outA", 1'b0, 7'h01, 4'd1, 10'b0000000001, 4'b0100, 1'b0);
    tick(); settle();
    chk_res("bp_outB", 1'b0, 7'h02, 4'd7, 10'b0000000111, 4'b1000, 1'b0);
    tick(); settle();
    chk("bp_empty", res_val, 0);
    tick();

    // flush t0 in S1 while t1 sits in S2
    res_rdy = 1'b0;
    set_req(1, 32'h00FF00FF, 32'h12345678, 3'b011, 1'b1, 7'h30);
    settle(); chk("fl_rdyX", t1_req_rdy, 1); tick(); idle();
    set_req(0, 32'h11111111, 32'h22222222, 3'b000, 1'b1, 7'h31);
    settle(); chk("fl_rdyY", t0_req_rdy, 1); tick(); idle();
    flush = 2'b10;
    settle(); chk("fl_s2_itag", res_itag, 7'h30); tick();
    flush = 2'b00; res_rdy = 1'b1; settle();
    chk_res("fl_outX", 1'b1, 7'h30, 4'd1, 10'b0110000001, 4'b0100, 1'b1);
    chk("fl_s1_clear", ctl_rs1, 0);
    tick(); settle(); chk("fl_noY_a", res_val, 0);
    tick(); settle(); chk("fl_noY_b", res_val, 0);

    // reset mid-operation with both stages full
    res_rdy = 1'b0;
    set_req(0, 32'h0, 32'h0, 3'b000, 1'b0, 7'h40); tick(); idle();
    set_req(1, 32'h0, 32'h0, 3'b000, 1'b0, 7'h41); tick(); idle();
    settle(); chk("mr_full", res_val, 1);
    rst = 1'b1; #1;
    chk("mr_val_now", res_val, 0);
    chk("mr_ctl_now", ctl_rs1 | ctl_rs2, 0);
    tick(); rst = 1'b0; res_rdy = 1'b1; settle();
    chk("mr_no_stale", res_val, 0);
    set_req(0, 32'h11223344, 32'h55660077, 3'b001, 1'b1, 7'h42);
    settle(); chk("mr_rdy", t0_req_rdy, 1); tick(); idle(); settle();
    chk("mr_no_stale2", res_val, 0);
    tick(); settle();
    chk_res("mr_out", 1'b0, 7'h42, 4'd7, 10'b0010000111, 4'b1000, 1'b1);
    tick();

    // randomized traffic against the reference model
    rst = 1'b1; tick(); rst = 1'b0;
    pipe.delete();
    last_g = 1;
    for (int c = 0; c < 600; c++) begin
      v0 = ($urandom_range(0, 99) < 70);
      v1 = ($urandom_range(0, 99) < 70);
      a0 = rnd_word(); b0 = rnd_word(); x0 = 3'($urandom); rc0 = 1'($urandom); tg0 = 7'($urandom);
      a1 = rnd_word(); b1 = rnd_word(); x1 = 3'($urandom); rc1 = 1'($urandom); tg1 = 7'($urandom);
      idle();
      if (v0) set_req(0, a0, b0, x0, rc0, tg0);
      if (v1) set_req(1, a1, b1, x1, rc1, tg1);
      flush   = ($urandom_range(0, 14) == 0) ? 2'($urandom) : 2'b00;
      res_rdy = ($urandom_range(0, 99) < 65);
      settle();

      has2    = (pipe.size() > 0) && (pipe[0].st == 2);
      deliver = has2 && res_rdy;
      idx1    = -1;
      foreach (pipe[i]) if (pipe[i].st == 1) idx1 = i;
      move    = (idx1 >= 0) && (!has2 || deliver) && !flush[pipe[idx1].tid];
      s1_free = (idx1 < 0) || move;
      e0 = v0 && !flush[0];
      e1 = v1 && !flush[1];
`ifdef XU0_DLMZB_RR_EN
      g0 = e0 && (!e1 || last_g == 1);
      g1 = e1 && (!e0 || last_g == 0);
`else
      g0 = e0;
      g1 = e1 && !e0;
`endif
      chk("rnd_rdy0", t0_req_rdy, s1_free && g0);
      chk("rnd_rdy1", t1_req_rdy, s1_free && g1);
      chk("rnd_res_val", res_val, has2);
      if (has2) begin
        r = dlmzb_ref(pipe[0].a, pipe[0].b, pipe[0].x);
        chk_res("rnd_res", pipe[0].tid, pipe[0].itag, r[3:0], r[17:8], r[7:4], pipe[0].rc);
      end

      nxt.delete();
      foreach (pipe[i]) begin
        e = pipe[i];
        if (e.st == 2) begin
          if (!deliver && !flush[e.tid]) nxt.push_back(e);
        end else if (move) begin
          e.st = 2;
          nxt.push_back(e);
        end else if (!flush[e.tid]) begin
          nxt.push_back(e);
        end
      end
      if (s1_free && (g0 || g1)) begin
        e.tid  = g1;
        e.itag = g1 ? tg1 : tg0;
        e.a    = g1 ? a1 : a0;
        e.b    = g1 ? b1 : b0;
        e.x    = g1 ? x1 : x0;
        e.rc   = g1 ? rc1 : rc0;
        e.st   = 1;
        nxt.push_back(e);
        last_g = g1 ? 1 : 0;
      end
      pipe = nxt;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
